// File: rtl/exe_arbiter.sv
// exe_arbiter: round-robin arbiter sharing one execute unit between two requesters,
// holding each operation through a multi-cycle EXEC and a RESP handshake.
`ifndef ALU_OP_BUS
`define ALU_OP_BUS 3:0
`endif
`ifndef REG_BUS
`define REG_BUS 31:0
`endif
`ifndef ALU_OP_NOP
`define ALU_OP_NOP 4'd0
`endif
`ifndef ALU_OP_ADD
`define ALU_OP_ADD 4'd1
`endif
`ifndef ALU_OP_MUL
`define ALU_OP_MUL 4'd3
`endif
`ifndef ALU_OP_BNE
`define ALU_OP_BNE 4'd4
`endif

module exe_arbiter #(
  parameter int unsigned MUL_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid_i,
  input  logic              req1_valid_i,
  output logic              req0_ready_o,
  output logic              req1_ready_o,
  input  logic [`ALU_OP_BUS] req0_op_i,
  input  logic [`ALU_OP_BUS] req1_op_i,
  input  logic [`REG_BUS]   req0_rs1_i,
  input  logic [`REG_BUS]   req0_rs2_i,
  input  logic [`REG_BUS]   req1_rs1_i,
  input  logic [`REG_BUS]   req1_rs2_i,
  output logic [`ALU_OP_BUS] alu_opcode_o,
  output logic [`REG_BUS]   alu_rs1_o,
  output logic [`REG_BUS]   alu_rs2_o,
  input  logic [`REG_BUS]   alu_result_i,
  output logic              resp_valid_o,
  output logic              resp_id_o,
  output logic [`REG_BUS]   resp_data_o,
  input  logic              resp_ready_i
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state_q, state_d;
  logic ptr_q, ptr_d, id_q, id_d, gnt0, gnt1;
  logic [3:0] cnt_q, cnt_d;
  logic [`ALU_OP_BUS] op_q, op_d, acc_op;
  logic [`REG_BUS] rs1_q, rs1_d, rs2_q, rs2_d, data_q, data_d;

  // Pointer only breaks ties; a lone valid requester always wins.
  assign gnt0 = state_q == IDLE && req0_valid_i && (!req1_valid_i || !ptr_q);
  assign gnt1 = state_q == IDLE && req1_valid_i && (!req0_valid_i || ptr_q);
  assign acc_op = gnt1 ? req1_op_i : req0_op_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      id_q    <= 1'b0;
      cnt_q   <= 4'd0;
      op_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    data_d  = data_q;
    case (state_q)
      IDLE: if (gnt0 || gnt1) begin
        state_d = EXEC;
        id_d    = gnt1;
        op_d    = acc_op;
        rs1_d   = gnt1 ? req1_rs1_i : req0_rs1_i;
        rs2_d   = gnt1 ? req1_rs2_i : req0_rs2_i;
        cnt_d   = acc_op == `ALU_OP_MUL ? 4'(MUL_CYCLES - 1) : 4'd0;
      end
      EXEC: begin
        cnt_d = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          data_d  = alu_result_i;
        end
      end
      RESP: if (resp_ready_i) begin
        state_d = IDLE;
        ptr_d   = !id_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready is gated by reset so nothing is offered while reset is held.
  always_comb begin
    req0_ready_o = gnt0 && rst;
    req1_ready_o = gnt1 && rst;
    alu_opcode_o = state_q == EXEC ? op_q : `ALU_OP_NOP;
    alu_rs1_o    = state_q == EXEC ? rs1_q : '0;
    alu_rs2_o    = state_q == EXEC ? rs2_q : '0;
    resp_valid_o = state_q == RESP;
    resp_id_o    = id_q;
    resp_data_o  = data_q;
  end
endmodule

// File: doc/exe_arbiter.md
EXE_ARBITER -- requirements
Module: exe_arbiter

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 3: number of EXEC cycles for `ALU_OP_MUL`, legal range 1..15.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports req0_valid_i / req1_valid_i  input  1  each requester has an operation pending.
REQ-005 SHALL have ports req0_ready_o / req1_ready_o  output  1  the operation is accepted this cycle.
REQ-006 SHALL have ports reqN_op_i  input  `ALU_OP_BUS`  opcode from each requester.
REQ-007 SHALL have ports reqN_rs1_i and reqN_rs2_i  input  `REG_BUS`  operands from each requester.
REQ-008 SHALL have port alu_opcode_o  output  `ALU_OP_BUS`  opcode driven to the shared execute unit.
REQ-009 SHALL have ports alu_rs1_o and alu_rs2_o  output  `REG_BUS`  operands driven to the shared execute unit.
REQ-010 SHALL have port alu_result_i  input  `REG_BUS`  combinational result returned by the execute unit.
REQ-011 SHALL have port resp_valid_o  output  1  a response is available.
REQ-012 SHALL have port resp_id_o  output  1  requester index owning the response.
REQ-013 SHALL have port resp_data_o  output  `REG_BUS`  the captured result.
REQ-014 SHALL have port resp_ready_i  input  1  the consumer accepts the response.

Function
REQ-015 SHALL implement a state machine with states IDLE, EXEC and RESP.
REQ-016 SHALL hold a one-bit round-robin pointer naming the requester that wins when both are valid.
REQ-017 In IDLE, SHALL grant the only valid requester, or the pointer's requester if both are valid.
REQ-018 In IDLE, SHALL assert reqN_ready_o combinationally for the granted N only.
REQ-019 SHALL hold both ready outputs low in EXEC and RESP.
REQ-020 On accept (valid && ready), SHALL latch the requester's op, rs1, rs2 and id, then enter EXEC.
REQ-021 On accept, SHALL load the cycle counter with latency-1, where latency = MUL_CYCLES for `ALU_OP_MUL` and 1 for every other opcode, including unknown opcodes.
REQ-022 In EXEC, SHALL drive alu_opcode_o, alu_rs1_o and alu_rs2_o from the latched registers, stable for every EXEC cycle.
REQ-023 Outside EXEC, SHALL drive alu_opcode_o = `ALU_OP_NOP` and alu_rs1_o = alu_rs2_o = 0.
REQ-024 In EXEC, SHALL decrement the counter each cycle.
REQ-025 In the EXEC cycle where the counter is 0, SHALL register alu_result_i into resp_data_o and enter RESP.
REQ-026 Timing: accept at edge T gives resp_valid_o high after edge T+latency+1; ADD shows it 2 cycles after accept, MUL with default 3 shows it 4 cycles after accept.
REQ-027 In RESP, SHALL assert resp_valid_o and hold resp_id_o and resp_data_o stable until resp_ready_i is high.
REQ-028 On the RESP handshake, SHALL return to IDLE and set the pointer to the requester not just served.
REQ-029 Back-to-back operations SHALL reach at most one per latency+2 cycles; no new accept in the handshake cycle.
REQ-030 A requester SHALL keep valid and payload stable until ready; the block does not check this.
REQ-031 Deasserting valid before accept SHALL NOT cause a grant or change the pointer.
REQ-032 resp_ready_i SHALL be ignored outside RESP.

Reset
REQ-033 While rst=0, SHALL force state=IDLE, pointer=0, counter=0, latched registers=0, resp_valid_o=0, resp_id_o=0 and resp_data_o=0, immediately and without a clock.
REQ-034 While rst=0, both ready outputs SHALL be 0.
REQ-035 Reset in EXEC or RESP SHALL abort the operation silently: no response, and the first grant after release follows REQ-017 with pointer 0.

Verification
REQ-036 Single ADD: req0 valid, rs1=5, rs2=7 -> req0_ready_o=1 in the same cycle; resp_valid_o=1 two cycles later with id=0 and data=12.
REQ-037 Contention: both valid from reset, req0 ADD 1+1, req1 BNE 3,3 -> req0 served first (data 2), then req1 (data 0, id=1).
REQ-038 MUL with MUL_CYCLES=3: 6*7 -> alu_opcode_o = MUL for exactly 3 cycles; resp data 42 four cycles after accept.
REQ-039 Backpressure: resp_ready_i held 0 for 5 cycles -> resp_valid_o, resp_id_o and resp_data_o constant; both ready outputs 0; no second accept.
REQ-040 Reset mid-EXEC of a MUL -> resp_valid_o never rises; the next accept goes to req0 when both are valid.
REQ-041 Fairness: both requesters continuously valid for 10 operations -> resp_id_o alternates 0,1,0,1...
